// File: rtl/mem_access.sv
// Load/store unit bridging the execute stage to a single-beat req/ack bus.
// Optional alignment checking is enabled by defining MEM_ACCESS_ALIGN_CHECK_EN.
module mem_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [2:0]  mem_op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        fault_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_FIN
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;

    logic        sz_byte, sz_half, is_store, misaligned;
    logic [3:0]  be_new;
    logic [31:0] wdata_new, load_val;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Request decode from the live inputs; only used on the IDLE->REQ edge.
    always_comb begin
        sz_byte  = (mem_op_i == 3'd0) || (mem_op_i == 3'd3) || (mem_op_i == 3'd5);
        sz_half  = (mem_op_i == 3'd1) || (mem_op_i == 3'd4) || (mem_op_i == 3'd6);
        is_store = (mem_op_i >= 3'd5);
        if (sz_byte) begin
            be_new    = 4'b0001 << addr_i[1:0];
            wdata_new = {4{wdata_i[7:0]}};
        end else if (sz_half) begin
            be_new    = addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_new = {2{wdata_i[15:0]}};
        end else begin
            be_new    = 4'b1111;
            wdata_new = wdata_i;
        end
    end

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    always_comb misaligned = (sz_half && addr_i[0]) ||
                             (!sz_byte && !sz_half && (addr_i[1:0] != 2'b00));
`else
    always_comb misaligned = 1'b0;
`endif

    always_comb begin
        rd_byte = bus_rdata_i[{off_q, 3'b000} +: 8];
        rd_half = off_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        case (op_q)
            3'd0:    load_val = {{24{rd_byte[7]}}, rd_byte};
            3'd1:    load_val = {{16{rd_half[15]}}, rd_half};
            3'd2:    load_val = bus_rdata_i;
            3'd3:    load_val = {24'd0, rd_byte};
            3'd4:    load_val = {16'd0, rd_half};
            default: load_val = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        off_d       = off_q;
        rdata_d     = rdata_q;
        fault_d     = fault_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    op_d    = mem_op_i;
                    off_d   = addr_i[1:0];
                    cnt_d   = '0;
                    fault_d = 1'b0;
                    if (misaligned) begin
                        state_d = S_FIN;
                        fault_d = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d     = S_REQ;
                        bus_req_d   = 1'b1;
                        bus_we_d    = is_store;
                        bus_addr_d  = {addr_i[31:2], 2'b00};
                        bus_be_d    = be_new;
                        bus_wdata_d = wdata_new;
                    end
                end
            end
            S_REQ: begin
                // An ack arriving on the final allowed cycle still completes normally.
                if (bus_ack_i) begin
                    state_d   = S_FIN;
                    bus_req_d = 1'b0;
                    fault_d   = 1'b0;
                    rdata_d   = load_val;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_FIN;
                    bus_req_d = 1'b0;
                    fault_d   = 1'b1;
                    rdata_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            off_q       <= '0;
            rdata_q     <= '0;
            fault_q     <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            off_q       <= off_d;
            rdata_q     <= rdata_d;
            fault_q     <= fault_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign busy_o      = (state_q == S_REQ);
    assign done_o      = (state_q == S_FIN);
    assign fault_o     = fault_q && (state_q == S_FIN);
    assign rdata_o     = rdata_q;
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_be_o    = bus_be_q;
    assign bus_wdata_o = bus_wdata_q;

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, number of cycles bus_req may wait for bus_ack before abort; legal range 1..65535.
REQ-002 clk  in  1  rising-edge clock; sole clock.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  one-cycle request from execute stage; sampled only in IDLE.
REQ-005 mem_op  in  3  0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW.
REQ-006 addr  in  32  byte address, taken directly from the ALU result.
REQ-007 wdata  in  32  store data; low byte/halfword used for SB/SH.
REQ-008 busy  out  1  high from the cycle after start until done.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 rdata  out  32  extended load result; valid while done=1, held until next done.
REQ-011 fault  out  1  high with done when access was misaligned or timed out.
REQ-012 bus_req  out  1  bus request, held until bus_ack or abort.
REQ-013 bus_we  out  1  1 = write.
REQ-014 bus_addr  out  32  {addr[31:2], 2'b00}.
REQ-015 bus_be  out  4  byte enables, little-endian lanes.
REQ-016 bus_wdata  out  32  store data replicated onto the addressed lanes.
REQ-017 bus_ack  in  1  slave accept/complete; single cycle.
REQ-018 bus_rdata  in  32  read data, valid when bus_ack=1.

Function
REQ-019 FSM states SHALL be IDLE, REQ, FIN.
REQ-020 IDLE + start=1: latch mem_op, addr, wdata; go REQ (or FIN with fault on misalignment, REQ-028); start while not IDLE SHALL be ignored.
REQ-021 In REQ, bus_req=1 and all bus_* outputs SHALL be registered and stable until exit.
REQ-022 REQ + bus_ack=1: capture bus_rdata, go FIN; minimum latency start->done = 2 cycles (ack in first REQ cycle).
REQ-023 FIN: done=1 for exactly one cycle, busy=0 in the same cycle, return to IDLE; start in FIN is ignored.
REQ-024 Wait counter SHALL clear on REQ entry, increment each REQ cycle without ack; when it reaches TIMEOUT_CYCLES with no ack, drop bus_req, go FIN with fault=1, rdata=0.
REQ-025 bus_ack in the same cycle the counter hits the limit SHALL win: normal completion, fault=0.
REQ-026 bus_be: byte 1<<addr[1:0]; halfword 4'b0011 or 4'b1100 by addr[1]; word 4'b1111.
REQ-027 Loads: select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unmodified.
REQ-028 Misaligned (halfword addr[0]=1; word addr[1:0]!=0) handled per REQ-033/034.
REQ-029 bus_ack outside REQ SHALL be ignored.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, counter 0, and busy, done, fault, bus_req, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, rdata=0.
REQ-031 Reset asserted in REQ SHALL drop bus_req asynchronously; no done is issued for the aborted access.
REQ-032 After rst_n rises, first start SHALL be accepted on the first clk edge.

Configuration
REQ-033 Macro MEM_ACCESS_ALIGN_CHECK_EN defined: misaligned request issues no bus cycle; FSM goes IDLE->FIN, done with fault=1, rdata=0.
REQ-034 Macro undefined: no check; offending low address bits are ignored (halfword uses addr[1], word uses lane 0), access proceeds normally, fault only on timeout.

Verification
REQ-035 LB addr=0x1003, bus_rdata=0x80FF_FF00, ack first REQ cycle -> done 2 cycles after start, rdata=0xFFFF_FF80, bus_be=4'b1000, bus_addr=0x1000.
REQ-036 SH addr=0x2002, wdata=0x0000_BEEF -> bus_we=1, bus_be=4'b1100, bus_wdata upper half=0xBEEF; done after ack 3 cycles late, fault=0.
REQ-037 LW addr=0x0, bus_ack never, TIMEOUT_CYCLES=4 -> bus_req drops after 4 REQ cycles, done with fault=1, rdata=0.
REQ-038 With MEM_ACCESS_ALIGN_CHECK_EN, LW addr=0x0000_0006 -> bus_req never rises, done with fault=1 one cycle after start; without macro -> bus_addr=0x4, normal completion.
REQ-039 rst_n low for 1 cycle mid-REQ -> bus_req=0 immediately, no done; next start LHU addr=0x2, rdata=0x0000_8001 from bus_rdata=0x8001_xxxx.
